// File: rtl/dice_pkg.sv
// Shared constants, state types and the die-face table for the dice RNG
// custom-instruction initiator.
package dice_pkg;

  localparam int SUM_W     = 11;
  localparam int MAX_COUNT = 15;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  localparam logic [3:0] IDLE_CODE = 4'hF;
  localparam logic [3:0] DIE_D4    = 4'd0;
  localparam logic [3:0] DIE_D6    = 4'd1;
  localparam logic [3:0] DIE_D8    = 4'd2;
  localparam logic [3:0] DIE_D10   = 4'd3;
  localparam logic [3:0] DIE_D12   = 4'd4;
  localparam logic [3:0] DIE_D20   = 4'd5;
  localparam logic [3:0] DIE_D100  = 4'd6;

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACCUM, ST_RESP} seq_state_e;
  typedef enum logic [1:0] {CI_IDLE, CI_ISSUE, CI_WAIT} ci_state_e;

  // A zero return doubles as the "unknown die code" marker.
  function automatic logic [6:0] max_face(input logic [3:0] die);
    case (die)
      DIE_D4:   max_face = 7'd4;
      DIE_D6:   max_face = 7'd6;
      DIE_D8:   max_face = 7'd8;
      DIE_D10:  max_face = 7'd10;
      DIE_D12:  max_face = 7'd12;
      DIE_D20:  max_face = 7'd20;
      DIE_D100: max_face = 7'd100;
      default:  max_face = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ci_initiator.sv
// Single custom-instruction transaction engine: start pulse, dataa hold,
// done detection and timeout counting for one die.
module ci_initiator
  import dice_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go_i,
  input  logic [3:0]  die_i,
  output logic        busy_o,
  output logic        ok_o,
  output logic        timeout_o,
  output logic [6:0]  face_o,
  output logic        ci_start_o,
  output logic [31:0] ci_dataa_o,
  input  logic        ci_done_i,
  input  logic [6:0]  ci_result_i
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

  ci_state_e     state_q;
  logic [TW-1:0] timer_q;
  logic          start_q;
  logic [31:0]   dataa_q;
  logic          in_wait;

  // ok/timeout are combinational so the caller can leave WAIT on the same edge.
  assign in_wait    = (state_q == CI_WAIT);
  assign ok_o       = in_wait && ci_done_i;
  assign timeout_o  = in_wait && !ci_done_i && (timer_q == LAST_TICK);
  assign face_o     = ci_result_i;
  assign busy_o     = (state_q != CI_IDLE);
  assign ci_start_o = start_q;
  assign ci_dataa_o = dataa_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CI_IDLE;
      timer_q <= '0;
      start_q <= 1'b0;
      dataa_q <= {28'b0, IDLE_CODE};
    end else begin
      start_q <= 1'b0;
      case (state_q)
        CI_IDLE: begin
          if (go_i) begin
            state_q <= CI_ISSUE;
            start_q <= 1'b1;
            timer_q <= '0;
            dataa_q <= {28'b0, die_i};
          end
        end
        CI_ISSUE: state_q <= CI_WAIT;
        CI_WAIT: begin
          if (ci_done_i || (timer_q == LAST_TICK)) begin
            state_q <= CI_IDLE;
            dataa_q <= {28'b0, IDLE_CODE};
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= CI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Dice roll request sequencer: loops one CI transaction per die, range-checks
// and sums the faces, and returns the total on a valid/ready response port.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_die,
  input  logic [3:0]       req_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SUM_W-1:0] rsp_sum,
  output logic             rsp_error,
  output logic             roll_valid,
  output logic [6:0]       roll_value,
  output logic             ci_clk_en,
  output logic             ci_start,
  output logic [31:0]      ci_dataa,
  output logic [31:0]      ci_datab,
  input  logic [31:0]      ci_result,
  input  logic             ci_done
);

  seq_state_e       state_q;
  logic [3:0]       die_q;
  logic [CNT_W-1:0] remaining_q;
  logic [SUM_W-1:0] sum_q;
  logic             err_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             roll_valid_q;
  logic [6:0]       roll_value_q;
  logic             clk_en_q;

  logic       ci_go_d;
  logic [3:0] ci_die_d;
  logic       ci_busy;
  logic       ci_ok;
  logic       ci_timeout;
  logic [6:0] ci_face;
  logic       face_ok;
  logic       unused_bits;

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_sum     = sum_q;
  assign rsp_error   = err_q;
  assign roll_valid  = roll_valid_q;
  assign roll_value  = roll_value_q;
  assign ci_clk_en   = clk_en_q;
  assign ci_datab    = '0;
  assign face_ok     = (ci_face != 7'd0) && (ci_face <= max_face(die_q));
  assign unused_bits = ^{ci_result[31:7], ci_busy};

  // Launch a transaction on a valid accept, or from ACCUM while dice remain.
  always_comb begin
    ci_go_d  = 1'b0;
    ci_die_d = die_q;
    if (state_q == ST_IDLE && req_valid && max_face(req_die) != 7'd0) begin
      ci_go_d  = 1'b1;
      ci_die_d = req_die;
    end else if (state_q == ST_ACCUM && remaining_q > CNT_W'(1)) begin
      ci_go_d = 1'b1;
    end
  end

  ci_initiator #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ci (
    .clk         (clk),
    .reset_n     (reset_n),
    .go_i        (ci_go_d),
    .die_i       (ci_die_d),
    .busy_o      (ci_busy),
    .ok_o        (ci_ok),
    .timeout_o   (ci_timeout),
    .face_o      (ci_face),
    .ci_start_o  (ci_start),
    .ci_dataa_o  (ci_dataa),
    .ci_done_i   (ci_done),
    .ci_result_i (ci_result[6:0])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      die_q        <= IDLE_CODE;
      remaining_q  <= '0;
      sum_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      roll_valid_q <= 1'b0;
      roll_value_q <= '0;
      clk_en_q     <= 1'b0;
    end else begin
      roll_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            die_q       <= req_die;
            remaining_q <= (req_count == '0) ? CNT_W'(1) : req_count;
            sum_q       <= '0;
            req_ready_q <= 1'b0;
            clk_en_q    <= 1'b1;
            if (max_face(req_die) != 7'd0) begin
              err_q   <= 1'b0;
              state_q <= ST_ISSUE;
            end else begin
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (ci_ok) begin
            state_q <= ST_ACCUM;
            if (face_ok) begin
              roll_valid_q <= 1'b1;
              roll_value_q <= ci_face;
            end else begin
              err_q <= 1'b1;
            end
          end else if (ci_timeout) begin
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_ACCUM: begin
          if (roll_valid_q) begin
            sum_q <= sum_q + SUM_W'(roll_value_q);
          end
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q > CNT_W'(1)) begin
            state_q <= ST_ISSUE;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            clk_en_q    <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Self-checking bench: a per-cycle timeline model built from the roll rules,
// compared against the DUT every cycle, plus literal pins per scenario.
module tb_dice_roll_sequencer;

  localparam int TIMEOUT = 16;
  localparam int MAXC    = 128;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_die;
  logic [3:0]  req_count;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [10:0] rsp_sum;
  logic        rsp_error;
  logic        roll_valid;
  logic [6:0]  roll_value;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [31:0] ci_result;
  logic        ci_done;

  int expStart [MAXC];
  int expDataa [MAXC];
  int expClkEn [MAXC];
  int expReqReady [MAXC];
  int expRspValid [MAXC];
  int expRollValid [MAXC];
  int expRollValue [MAXC];
  int drvDone [MAXC];
  int drvRes [MAXC];
  int drvReady [MAXC];
  int faceMax [7] = '{4, 6, 8, 10, 12, 20, 100};
  int planFace [4];
  int planK [4];
  int modelSum;
  int modelErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tracking = 1'b0;
  int seenStarts, seenRolls, rspCycles, rspCycle, rspSum, rspErr;
  bit seenRsp;

  dice_roll_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_die    (req_die),
    .req_count  (req_count),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_error  (rsp_error),
    .roll_valid (roll_valid),
    .roll_value (roll_value),
    .ci_clk_en  (ci_clk_en),
    .ci_start   (ci_start),
    .ci_dataa   (ci_dataa),
    .ci_datab   (ci_datab),
    .ci_result  (ci_result),
    .ci_done    (ci_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    checkOutput({tag, "_rsp_sum"}, 32'(rsp_sum), 0);
    checkOutput({tag, "_rsp_error"}, 32'(rsp_error), 0);
    checkOutput({tag, "_roll_valid"}, 32'(roll_valid), 0);
    checkOutput({tag, "_roll_value"}, 32'(roll_value), 0);
    checkOutput({tag, "_ci_start"}, 32'(ci_start), 0);
    checkOutput({tag, "_ci_clk_en"}, 32'(ci_clk_en), 0);
    checkOutput({tag, "_ci_dataa"}, ci_dataa, 32'hF);
    checkOutput({tag, "_ci_datab"}, ci_datab, 0);
  endtask

  // Builds the expected timeline and responder script, then plays it out.
  task automatic applyStimulus(input int die, input int count, input int hold, input bit stray);
    int n, c, resp, rel, lastCyc, acc, f;
    bit timedOut;
    for (int j = 0; j < MAXC; j++) begin
      expStart[j] = 0; expDataa[j] = 15; expClkEn[j] = 1; expReqReady[j] = 0;
      expRspValid[j] = 0; expRollValid[j] = 0; expRollValue[j] = 0;
      drvDone[j] = 0; drvRes[j] = 0; drvReady[j] = 0;
    end
    n = (count == 0) ? 1 : count;
    modelSum = 0;
    modelErr = 0;
    timedOut = 1'b0;
    resp = 1;
    if (die > 6) begin
      modelErr = 1;
    end else begin
      c = 1;
      for (int d = 0; d < n && !timedOut; d++) begin
        expStart[c] = 1;
        if (stray) begin
          drvDone[c] = 1;
          drvRes[c] = 127;
        end
        if (planK[d] == 0) begin
          for (int j = c; j <= c + TIMEOUT; j++) expDataa[j] = die;
          c = c + TIMEOUT + 1;
          modelErr = 1;
          timedOut = 1'b1;
        end else begin
          for (int j = c; j <= c + planK[d]; j++) expDataa[j] = die;
          f = planFace[d];
          drvDone[c + planK[d]] = 1;
          drvRes[c + planK[d]] = f + 128 * 5;
          acc = c + planK[d] + 1;
          if (f >= 1 && f <= faceMax[die]) begin
            expRollValid[acc] = 1;
            expRollValue[acc] = f;
            modelSum += f;
          end else begin
            modelErr = 1;
          end
          c = acc + 1;
        end
      end
      resp = c;
    end
    rel = resp + hold;
    for (int j = resp; j <= rel; j++) expRspValid[j] = 1;
    drvReady[rel] = 1;
    lastCyc = rel + 1;
    expReqReady[lastCyc] = 1;
    expClkEn[lastCyc] = 0;

    seenStarts = 0; seenRolls = 0; rspCycles = 0; rspCycle = -1;
    rspSum = -1; rspErr = -1; seenRsp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_die = die[3:0];
    req_count = count[3:0];
    for (int k = 1; k <= lastCyc; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      tracking = 1'b1;
      req_valid = 1'b0;
      ci_done = drvDone[k][0];
      ci_result = drvRes[k];
      rsp_ready = drvReady[k][0];
    end
    @(posedge clk);
    tracking = 1'b0;
    #1;
    ci_done = 1'b0;
    rsp_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (tracking) begin
      checkOutput("ci_start", 32'(ci_start), expStart[cyc]);
      checkOutput("ci_dataa", ci_dataa, expDataa[cyc]);
      checkOutput("ci_datab", ci_datab, 0);
      checkOutput("ci_clk_en", 32'(ci_clk_en), expClkEn[cyc]);
      checkOutput("req_ready", 32'(req_ready), expReqReady[cyc]);
      checkOutput("rsp_valid", 32'(rsp_valid), expRspValid[cyc]);
      checkOutput("roll_valid", 32'(roll_valid), expRollValid[cyc]);
      if (expRollValid[cyc] != 0) checkOutput("roll_value", 32'(roll_value), expRollValue[cyc]);
      if (expRspValid[cyc] != 0) begin
        checkOutput("rsp_sum", 32'(rsp_sum), modelSum);
        checkOutput("rsp_error", 32'(rsp_error), modelErr);
      end
      if (ci_start) seenStarts++;
      if (roll_valid) seenRolls++;
      if (rsp_valid) begin
        rspCycles++;
        if (!seenRsp) begin
          seenRsp = 1'b1;
          rspCycle = cyc;
          rspSum = int'(rsp_sum);
          rspErr = int'(rsp_error);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    req_valid = 1'b0; req_die = 4'd0; req_count = 4'd0;
    rsp_ready = 1'b0; ci_result = '0; ci_done = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");
    reset_n = 1'b1;

    $display("[TB] D20 x1");
    planFace = '{13, 0, 0, 0}; planK = '{2, 0, 0, 0};
    applyStimulus(5, 1, 0, 1'b0);
    checkOutput("d20_rspcyc", rspCycle, 5);
    checkOutput("d20_sum", rspSum, 13);
    checkOutput("d20_err", rspErr, 0);
    checkOutput("d20_rolls", seenRolls, 1);

    $display("[TB] D6 x3 with stray done in ISSUE");
    planFace = '{2, 6, 1, 0}; planK = '{1, 3, 2, 0};
    applyStimulus(1, 3, 0, 1'b1);
    checkOutput("d6_starts", seenStarts, 3);
    checkOutput("d6_sum", rspSum, 9);
    checkOutput("d6_err", rspErr, 0);
    checkOutput("d6_rspcyc", rspCycle, 13);

    $display("[TB] D8 x2 with out-of-range face");
    planFace = '{9, 4, 0, 0}; planK = '{1, 1, 0, 0};
    applyStimulus(2, 2, 0, 1'b0);
    checkOutput("d8_rolls", seenRolls, 1);
    checkOutput("d8_sum", rspSum, 4);
    checkOutput("d8_err", rspErr, 1);

    $display("[TB] invalid die codes");
    applyStimulus(15, 5, 2, 1'b0);
    checkOutput("badF_starts", seenStarts, 0);
    checkOutput("badF_rspcyc", rspCycle, 1);
    checkOutput("badF_err", rspErr, 1);
    applyStimulus(7, 0, 0, 1'b0);
    checkOutput("bad7_sum", rspSum, 0);
    checkOutput("bad7_err", rspErr, 1);

    $display("[TB] D10 count 0 at max face");
    planFace = '{10, 0, 0, 0}; planK = '{1, 0, 0, 0};
    applyStimulus(3, 0, 0, 1'b0);
    checkOutput("d10_starts", seenStarts, 1);
    checkOutput("d10_sum", rspSum, 10);

    $display("[TB] D100 x2 with timeout");
    planFace = '{100, 0, 0, 0}; planK = '{2, 0, 0, 0};
    applyStimulus(6, 2, 0, 1'b0);
    checkOutput("to_rspcyc", rspCycle, 22);
    checkOutput("to_sum", rspSum, 100);
    checkOutput("to_err", rspErr, 1);

    $display("[TB] D4 x2 with response backpressure");
    planFace = '{3, 4, 0, 0}; planK = '{1, 1, 0, 0};
    applyStimulus(0, 2, 10, 1'b0);
    checkOutput("bp_rspcycles", rspCycles, 11);
    checkOutput("bp_sum", rspSum, 7);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    req_valid = 1'b1; req_die = 4'd4; req_count = 4'd2;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkResetState("midrst");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ci_done = 1'b1; ci_result = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stray_ci_start", 32'(ci_start), 0);
      checkOutput("stray_roll_valid", 32'(roll_valid), 0);
      checkOutput("stray_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("stray_req_ready", 32'(req_ready), 1);
    end
    ci_done = 1'b0;

    $display("[TB] D12 x1 after reset");
    planFace = '{12, 0, 0, 0}; planK = '{3, 0, 0, 0};
    applyStimulus(4, 1, 0, 1'b0);
    checkOutput("post_sum", rspSum, 12);
    checkOutput("post_rspcyc", rspCycle, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Initiator side of the dice RNG custom-instruction interface. Accepts a roll request (die type, number of dice), issues one custom-instruction transaction per die to the RNG responder, range-checks and sums the returned faces, and returns the total on a valid/ready response port. It sits between the front-end request logic and the RNG instruction block. It owns all start/dataa sequencing, so the RNG never sees a request it cannot serve.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles to wait in WAIT for `ci_done` before aborting.
- `MAX_COUNT`, 15: largest accepted dice count.
- `IDLE_CODE`, 4'hF: die code driven on `ci_dataa[3:0]` when no transaction is pending.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: roll request present.
- `req_ready` out 1: request accepted when both are high.
- `req_die` in 4: die code. 0=D4, 1=D6, 2=D8, 3=D10, 4=D12, 5=D20, 6=D100; any other value is invalid.
- `req_count` in 4: number of dice; 0 is treated as 1.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: result consumed when both are high.
- `rsp_sum` out 11: sum of accepted faces (max 15×100 = 1500).
- `rsp_error` out 1: invalid die, timeout, or an out-of-range face occurred.
- `roll_valid` out 1: one-cycle pulse per accepted face.
- `roll_value` out 7: the face for that pulse.
- `ci_clk_en` out 1: high whenever the FSM is not IDLE.
- `ci_start` out 1: one-cycle start pulse.
- `ci_dataa` out 32: `{28'b0, die}` in ISSUE/WAIT; `{28'b0, IDLE_CODE}` otherwise.
- `ci_datab` out 32: constant 0.
- `ci_result` in 32: face in `[6:0]`; upper bits ignored.
- `ci_done` in 1: responder completion, sampled only in WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACCUM, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake: latch die, set `remaining` = max(count,1), clear sum and error.
  - Valid die goes to ISSUE.
  - Invalid die goes directly to RESP with `rsp_error`=1, sum 0, and no CI transaction issued.
- ISSUE: `ci_start`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Hold `ci_dataa` stable.
  - On `ci_done`, capture `ci_result[6:0]` and go to ACCUM.
  - Otherwise increment the timeout counter. At `TIMEOUT_CYCLES`, set error, drop the remaining dice, and go to RESP.
- ACCUM:
  - If the captured face is in 1..max_face(die): add it to sum and pulse `roll_valid`/`roll_value`.
  - If it is out of range: set the sticky error, add nothing, and do not pulse `roll_valid`.
  - Decrement `remaining`. Nonzero goes to ISSUE; zero goes to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_sum`/`rsp_error` are held stable until `rsp_ready`; then go to IDLE.
  - `rsp_valid` high in the same cycle as `rsp_ready` completes the handshake.
- `ci_done` outside WAIT is ignored, including a `ci_done` in the ISSUE cycle itself.
- Sum arithmetic is unsigned, 11 bits, and cannot overflow within the limits above.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_sum`=0, `rsp_error`=0, `roll_valid`=0, `roll_value`=0, `ci_start`=0, `ci_clk_en`=0, `ci_dataa`=`{28'b0, IDLE_CODE}`, `ci_datab`=0.
- Asserting `reset_n` low mid-transaction returns to IDLE immediately and discards the partial sum. No `ci_start` is issued while reset is asserted.
- All outputs are registered.
- Per die: 1 (ISSUE) + k (WAIT, with `ci_done` k≥1 cycles after start) + 1 (ACCUM) cycles.
- Accept edge at cycle 0: `ci_start` in cycle 1, and `rsp_valid` rises at cycle 1 + N·(k+2).
- Between consecutive dice, `ci_dataa` shows `IDLE_CODE` for exactly the ACCUM cycle.
- An invalid die gives `rsp_valid` in cycle 1.

## Structure
- Package `dice_pkg`:
  - die code constants and `IDLE_CODE`;
  - function `max_face(die)` returning 7 bits (4, 6, 8, 10, 12, 20, 100; 0 if invalid);
  - state enum;
  - `SUM_W`=11.
- Sub-module `ci_initiator`: one-transaction engine covering start pulse, dataa hold, done capture and timeout counter, with a go/busy/ok/timeout interface. The top-level FSM loops over dice around it.

## Test plan
- D20 (die 5), count 1; responder returns 13 with done 2 cycles after start. Expect `ci_start` in cycle 1, `roll_valid`/13, then `rsp_sum`=13, `rsp_error`=0 at cycle 5.
- D6, count 3; responder returns 2, 6, 1. Expect 3 start pulses, `ci_dataa`=0xF between them, `rsp_sum`=9, error 0.
- D8, count 2; responder returns 9, then 4. Expect a single `roll_valid` (4), `rsp_sum`=4, `rsp_error`=1.
- Die code 0xF (also 0x7), count 5. Expect no `ci_start`, `rsp_valid` at cycle 1, sum 0, error 1.
- D100, count 2, `TIMEOUT_CYCLES`=16; first roll returns 100, second never sends done. Expect `rsp_sum`=100 and error 1, 17 cycles after the second start.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 10 cycles: sum stays stable and `req_ready`=0.
  - Separately, pulse `reset_n` low during WAIT: all outputs return to reset values and a stray `ci_done` afterwards is ignored.
